// File: rtl/ldpc_bp_pkg.sv
// ldpc_bp_pkg: shared state encoding and default sizing for the BP iteration controller
package ldpc_bp_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ROW_GO, S_ROW_WAIT, S_COL_GO, S_COL_WAIT, S_CHECK, S_FIN
  } state_t;
  localparam int DEF_MAX_ITER = 10;
  localparam int DEF_TIMEOUT = 1023;
  localparam int DEF_ITER_W = $clog2(DEF_MAX_ITER + 1);
  localparam int DEF_TO_W = $clog2(DEF_TIMEOUT + 1);
endpackage

// File: rtl/ldpc_bp_iteration_controller_if.sv
// ldpc_bp_iteration_controller_if: decode control and phase start/done handshake bundle
interface ldpc_bp_iteration_controller_if #(parameter int ITER_W = 4);
  logic dec_start, abort, row_done, col_done, parity_ok;
  logic clr_msg, row_start, col_start, dec_busy, dec_done, dec_success, dec_timeout;
  logic [ITER_W-1:0] iter_count;
  modport master (
    input dec_start, abort, row_done, col_done, parity_ok,
    output clr_msg, row_start, col_start, dec_busy, dec_done, dec_success, dec_timeout, iter_count
  );
  modport slave (
    output dec_start, abort, row_done, col_done, parity_ok,
    input clr_msg, row_start, col_start, dec_busy, dec_done, dec_success, dec_timeout, iter_count
  );
endinterface

// File: rtl/ldpc_phase_watchdog.sv
// ldpc_phase_watchdog: counts cycles spent waiting on a phase, flags the TIMEOUT-th cycle
module ldpc_phase_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [TO_W-1:0] cnt;
  assign expired = en && cnt == TO_W'(TIMEOUT - 1);
  // count wait cycles, saturating once the limit cycle is reached
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ldpc_bp_iteration_controller.sv
// ldpc_bp_iteration_controller: sequences row/column BP phases until parity, iteration limit, timeout or abort
module ldpc_bp_iteration_controller
  import ldpc_bp_pkg::*;
#(
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int ITER_W = DEF_ITER_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W = DEF_TO_W
) (
  input logic clk,
  input logic rst_n,
  ldpc_bp_iteration_controller_if.master bus
);
  state_t state, nxt;
  logic [ITER_W-1:0] iter_count, iter_inc;
  logic in_wait, wd_clr, wd_exp;
  logic clr_msg, row_start, col_start, dec_busy, dec_done, dec_success, dec_timeout;

  assign in_wait = state == S_ROW_WAIT || state == S_COL_WAIT;
  assign wd_clr = state == S_ROW_GO || state == S_COL_GO;
  assign iter_inc = iter_count + 1'b1;

  ldpc_phase_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wd (
    .clk(clk), .rst_n(rst_n), .clr(wd_clr), .en(in_wait), .expired(wd_exp)
  );

  // next state; a matching done wins over watchdog expiry, abort wins over all
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     nxt = bus.dec_start ? S_INIT : S_IDLE;
      S_INIT:     nxt = S_ROW_GO;
      S_ROW_GO:   nxt = S_ROW_WAIT;
      S_ROW_WAIT: nxt = bus.row_done ? S_COL_GO : wd_exp ? S_FIN : S_ROW_WAIT;
      S_COL_GO:   nxt = S_COL_WAIT;
      S_COL_WAIT: nxt = bus.col_done ? S_CHECK : wd_exp ? S_FIN : S_COL_WAIT;
      S_CHECK:    nxt = (bus.parity_ok || iter_inc == ITER_W'(MAX_ITER)) ? S_FIN : S_ROW_GO;
      default:    nxt = S_IDLE;
    endcase
    if (bus.abort) nxt = S_IDLE;
  end

  // state register with Moore outputs registered alongside it, plus decode status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      {clr_msg, row_start, col_start, dec_busy, dec_done, dec_success, dec_timeout} <= '0;
      iter_count <= '0;
    end else begin
      state <= nxt;
      clr_msg <= nxt == S_INIT;
      row_start <= nxt == S_ROW_GO;
      col_start <= nxt == S_COL_GO;
      dec_done <= nxt == S_FIN;
      dec_busy <= nxt != S_IDLE;
      if (bus.abort) {dec_success, dec_timeout} <= '0;
      else if (state == S_IDLE && bus.dec_start) begin
        iter_count <= '0;
        {dec_success, dec_timeout} <= '0;
      end else if (state == S_CHECK) begin
        iter_count <= iter_inc;
        dec_success <= bus.parity_ok;
      end else if (in_wait && nxt == S_FIN) dec_timeout <= 1'b1;
    end
  end

  assign bus.clr_msg = clr_msg;
  assign bus.row_start = row_start;
  assign bus.col_start = col_start;
  assign bus.dec_busy = dec_busy;
  assign bus.dec_done = dec_done;
  assign bus.dec_success = dec_success;
  assign bus.dec_timeout = dec_timeout;
  assign bus.iter_count = iter_count;
endmodule

// File: tb/tb_ldpc_bp_iteration_controller.sv
// tb_ldpc_bp_iteration_controller: table, random and directed checks of the BP iteration controller
module tb_ldpc_bp_iteration_controller;
  localparam int MAXI = 3;
  localparam int T = 8;

  typedef struct packed {
    logic [2:0][3:0] rd;
    logic [2:0][3:0] cd;
    logic [2:0] par;
    logic [7:0] lat;
    logic [3:0] nrow, ncol, iters;
    logic succ, to;
  } vec_t;

  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  vec_t tbl[6];

  ldpc_bp_iteration_controller_if #(.ITER_W(4)) b ();
  ldpc_bp_iteration_controller #(.MAX_ITER(MAXI), .ITER_W(4), .TIMEOUT(T), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_time_limit");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input int r0, r1, r2, c0, c1, c2, p, lat, nr, nc, it, s, t);
    vec_t v;
    v.rd = {4'(r2), 4'(r1), 4'(r0)};
    v.cd = {4'(c2), 4'(c1), 4'(c0)};
    v.par = 3'(p);
    v.lat = 8'(lat);
    v.nrow = 4'(nr);
    v.ncol = 4'(nc);
    v.iters = 4'(it);
    v.succ = 1'(s);
    v.to = 1'(t);
    return v;
  endfunction

  // decode outcome from the phase delays: each iteration costs GO+wait+GO+wait+CHECK,
  // a wait longer than T ends the decode after T wait cycles
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    int lat = 1, nr = 0, nc = 0, it = 0;
    bit s = 0, t = 0;
    for (int i = 0; i < MAXI && !s && !t; i++) begin
      nr++;
      lat += 1;
      if (int'(v.rd[i]) > T) begin lat += T; t = 1; end
      else begin
        lat += int'(v.rd[i]) + 1;
        nc++;
        if (int'(v.cd[i]) > T) begin lat += T; t = 1; end
        else begin lat += int'(v.cd[i]) + 1; it++; s = v.par[i]; end
      end
    end
    e.lat = 8'(lat);
    e.nrow = 4'(nr);
    e.ncol = 4'(nc);
    e.iters = 4'(it);
    e.succ = s;
    e.to = t;
    return e;
  endfunction

  // drive one decode, answering start pulses after the vector's delays, with stray pulses mixed in
  task automatic run_decode(input string tag, input vec_t v, output vec_t m);
    int lat = 0, nrow = 0, ncol = 0, k = 0;
    bit rw = 0, cw = 0;
    m = v;
    b.parity_ok = 1'($urandom_range(0, 1));
    b.dec_start = 1;
    step();
    b.dec_start = 0;
    chk({tag, "_clr_msg_n1"}, b.clr_msg, 1);
    chk({tag, "_iter_cleared"}, b.iter_count, 0);
    chk({tag, "_status_cleared"}, {b.dec_success, b.dec_timeout}, 0);
    while (!b.dec_done && lat < 300) begin
      lat++;
      b.row_done = 0;
      b.col_done = 0;
      b.dec_start = 1'($urandom_range(0, 3) == 0);
      if (b.row_start) begin nrow++; rw = 1; k = 0; end
      else if (rw) begin
        k++;
        if (k == int'(v.rd[nrow-1])) begin b.row_done = 1; rw = 0; end
        else begin
          b.col_done = 1'($urandom_range(0, 3) == 0);
          if (k >= T) rw = 0;
        end
      end
      if (b.col_start) begin ncol++; cw = 1; k = 0; end
      else if (cw) begin
        k++;
        if (k == int'(v.cd[ncol-1])) begin b.col_done = 1; b.parity_ok = v.par[ncol-1]; cw = 0; end
        else begin
          b.row_done = 1'($urandom_range(0, 3) == 0);
          if (k >= T) cw = 0;
        end
      end
      step();
    end
    b.dec_start = 0;
    b.row_done = 0;
    b.col_done = 0;
    chk({tag, "_done_seen"}, b.dec_done, 1);
    m.lat = 8'(lat);
    m.nrow = 4'(nrow);
    m.ncol = 4'(ncol);
    m.iters = b.iter_count;
    m.succ = b.dec_success;
    m.to = b.dec_timeout;
    step();
    chk({tag, "_busy_fall"}, b.dec_busy, 0);
    chk({tag, "_done_single"}, b.dec_done, 0);
    chk({tag, "_success_held"}, b.dec_success, m.succ);
  endtask

  task automatic compare(input string tag, input vec_t e, input vec_t m);
    chk({tag, "_latency"}, m.lat, e.lat);
    chk({tag, "_row_starts"}, m.nrow, e.nrow);
    chk({tag, "_col_starts"}, m.ncol, e.ncol);
    chk({tag, "_iter_count"}, m.iters, e.iters);
    chk({tag, "_success"}, m.succ, e.succ);
    chk({tag, "_timeout"}, m.to, e.to);
  endtask

  initial begin
    vec_t m, v;
    b.dec_start = 0; b.abort = 0; b.row_done = 0; b.col_done = 0; b.parity_ok = 0;
    // rd0..2, cd0..2, parity bits, latency, row starts, col starts, iters, success, timeout
    tbl[0] = mk(2, 1, 1, 3, 1, 1, 3'b001, 9, 1, 1, 1, 1, 0);
    tbl[1] = mk(1, 1, 1, 1, 1, 1, 3'b000, 16, 3, 3, 3, 0, 0);
    tbl[2] = mk(9, 1, 1, 1, 1, 1, 3'b000, 10, 1, 0, 0, 0, 1);
    tbl[3] = mk(8, 1, 1, 1, 1, 1, 3'b001, 13, 1, 1, 1, 1, 0);
    tbl[4] = mk(1, 1, 1, 1, 1, 1, 3'b100, 16, 3, 3, 3, 1, 0);
    tbl[5] = mk(4, 2, 1, 2, 9, 1, 3'b000, 22, 2, 2, 1, 0, 1);

    repeat (3) step();
    chk("reset_outputs", {b.clr_msg, b.row_start, b.col_start, b.dec_busy, b.dec_done,
                          b.dec_success, b.dec_timeout}, 0);
    chk("reset_iter", b.iter_count, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 6; i++) begin
      run_decode($sformatf("tbl%0d", i), tbl[i], m);
      compare($sformatf("tbl%0d", i), tbl[i], m);
    end

    chk("pre_abort_timeout_flag", b.dec_timeout, 1);
    b.dec_start = 1; b.abort = 1;
    step();
    b.dec_start = 0; b.abort = 0;
    chk("abort_vs_start_busy", b.dec_busy, 0);
    chk("abort_vs_start_clr", b.clr_msg, 0);
    chk("abort_clears_timeout", b.dec_timeout, 0);
    step();
    chk("abort_vs_start_idle", b.dec_busy, 0);

    b.row_done = 1; b.col_done = 1;
    step();
    b.row_done = 0; b.col_done = 0;
    chk("stray_idle_busy", b.dec_busy, 0);
    chk("stray_idle_starts", {b.row_start, b.col_start, b.clr_msg}, 0);

    b.dec_start = 1; step(); b.dec_start = 0;
    step();
    step(); b.row_done = 1;
    step(); b.row_done = 0;
    step(); b.col_done = 1; b.parity_ok = 0;
    step(); b.col_done = 0;
    step();
    chk("abort_seq_row_go2", b.row_start, 1);
    step(); b.row_done = 1;
    step(); b.row_done = 0;
    step(); b.abort = 1;
    step(); b.abort = 0;
    chk("abort_busy_low", b.dec_busy, 0);
    chk("abort_no_done", b.dec_done, 0);
    chk("abort_iter_kept", b.iter_count, 1);
    step();
    chk("abort_still_idle", {b.dec_busy, b.dec_done}, 0);

    b.dec_start = 1; step(); b.dec_start = 0;
    step();
    step(); b.col_done = 1; b.dec_start = 1;
    step(); b.col_done = 0; b.dec_start = 0;
    chk("stray_col_in_row_wait", {b.col_start, b.dec_busy}, 1);
    step(); b.row_done = 1;
    step(); b.row_done = 0;
    chk("row_done_to_col_go", b.col_start, 1);
    step(); b.col_done = 1; b.parity_ok = 0;
    step(); b.col_done = 0;
    step();
    chk("rst_seq_iter1", b.iter_count, 1);
    step(); rst_n = 0;
    step(); rst_n = 1;
    chk("midreset_outputs", {b.clr_msg, b.row_start, b.col_start, b.dec_busy, b.dec_done,
                             b.dec_success, b.dec_timeout}, 0);
    chk("midreset_iter", b.iter_count, 0);
    step();
    chk("midreset_idle", {b.dec_busy, b.dec_done}, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < MAXI; i++) begin
        v.rd[i] = ($urandom_range(0, 9) == 0) ? 4'(T + 1) : 4'($urandom_range(1, T));
        v.cd[i] = ($urandom_range(0, 9) == 0) ? 4'(T + 1) : 4'($urandom_range(1, T));
        v.par[i] = 1'($urandom_range(0, 2) == 0);
      end
      run_decode($sformatf("rnd%0d", n), v, m);
      compare($sformatf("rnd%0d", n), model(v), m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
